// File: rtl/limb_mac_accumulator_pkg.sv
// Shared constants, state encoding and limb-width helper for limb_mac_accumulator.
// Operands split into NUM_LIMBS limbs; one limb product per step, NUM_STEPS steps total.
package limb_mac_accumulator_pkg;

    localparam int NUM_LIMBS = 3;
    localparam int NUM_STEPS = NUM_LIMBS * NUM_LIMBS;
    localparam int STEP_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // An N-bit product comes from two N/2-bit operands of NUM_LIMBS limbs each.
    function automatic int limb_width(input int n);
        return n / (2 * NUM_LIMBS);
    endfunction

endpackage

// File: rtl/limb_mac_accumulator_mul.sv
// normal_multiplication_compute: combinational L x L -> 2L unsigned limb multiplier.
module normal_multiplication_compute #(
    parameter int L = 37
) (
    input  logic [L-1:0]   x_i,
    input  logic [L-1:0]   y_i,
    output logic [2*L-1:0] p_o
);

    assign p_o = {{L{1'b0}}, x_i} * {{L{1'b0}}, y_i};

endmodule

// File: rtl/limb_mac_accumulator.sv
// limb_mac_accumulator: sequential 3x3-limb schoolbook multiplier, N/2 x N/2 -> N bits.
// Define LIMB_MAC_PIPE_MUL_EN to register the limb product ahead of the accumulator.
module limb_mac_accumulator
    import limb_mac_accumulator_pkg::*;
#(
    parameter int N = 222
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N/2-1:0] a,
    input  logic [N/2-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   product
);

    localparam int L   = limb_width(N);
    localparam int SHW = $clog2(N);
    localparam logic [1:0] LAST_IDX = 2'(NUM_LIMBS - 1);

    state_e              state_q, state_d;
    logic [N/2-1:0]      a_q, a_d;
    logic [N/2-1:0]      b_q, b_d;
    logic [N-1:0]        acc_q, acc_d;
    logic [N-1:0]        product_q, product_d;
    logic [1:0]          i_q, i_d;
    logic [1:0]          j_q, j_d;
    logic [STEP_W-1:0]   step_q, step_d;

    logic [L-1:0]        limb_a_w;
    logic [L-1:0]        limb_b_w;
    logic [2*L-1:0]      p_w;
    logic [SHW-1:0]      shamt_w;
    logic                last_step_w;

    assign limb_a_w    = a_q[L*int'(i_q) +: L];
    assign limb_b_w    = b_q[L*int'(j_q) +: L];
    assign shamt_w     = SHW'(L) * (SHW'(i_q) + SHW'(j_q));
    assign last_step_w = (step_q == '0);

    normal_multiplication_compute #(
        .L (L)
    ) u_mul (
        .x_i (limb_a_w),
        .y_i (limb_b_w),
        .p_o (p_w)
    );

`ifdef LIMB_MAC_PIPE_MUL_EN
    logic [2*L-1:0]      pipe_p_q, pipe_p_d;
    logic [SHW-1:0]      pipe_sh_q, pipe_sh_d;
    logic                pipe_v_q, pipe_v_d;
    logic                drain_q, drain_d;
    logic [N-1:0]        add_term_w;

    assign add_term_w = {{(N-2*L){1'b0}}, pipe_p_q} << pipe_sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_p_q  <= '0;
            pipe_sh_q <= '0;
            pipe_v_q  <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            pipe_p_q  <= pipe_p_d;
            pipe_sh_q <= pipe_sh_d;
            pipe_v_q  <= pipe_v_d;
            drain_q   <= drain_d;
        end
    end
`else
    logic [N-1:0]        add_term_w;

    assign add_term_w = {{(N-2*L){1'b0}}, p_w} << shamt_w;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            i_q       <= i_d;
            j_q       <= j_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        i_d       = i_q;
        j_d       = j_q;
        step_d    = step_q;
`ifdef LIMB_MAC_PIPE_MUL_EN
        pipe_p_d  = pipe_p_q;
        pipe_sh_d = pipe_sh_q;
        pipe_v_d  = pipe_v_q;
        drain_d   = drain_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    step_d  = STEP_W'(NUM_STEPS - 1);
`ifdef LIMB_MAC_PIPE_MUL_EN
                    pipe_v_d = 1'b0;
                    drain_d  = 1'b0;
`endif
                end
            end

            ST_RUN: begin
`ifdef LIMB_MAC_PIPE_MUL_EN
                if (pipe_v_q) begin
                    acc_d = acc_q + add_term_w;
                end
                if (drain_q) begin
                    pipe_v_d  = 1'b0;
                    drain_d   = 1'b0;
                    product_d = acc_d;
                    state_d   = ST_DONE;
                end else begin
                    pipe_p_d  = p_w;
                    pipe_sh_d = shamt_w;
                    pipe_v_d  = 1'b1;
                    if (last_step_w) begin
                        drain_d = 1'b1;
                    end
                end
`else
                acc_d = acc_q + add_term_w;
                if (last_step_w) begin
                    product_d = acc_d;
                    state_d   = ST_DONE;
                end
`endif
                // Row-major walk: j is the fast index, both wrap to 0 after the last step.
                if (!last_step_w) begin
                    step_d = step_q - STEP_W'(1);
                    if (j_q == LAST_IDX) begin
                        j_d = '0;
                        i_d = i_q + 2'd1;
                    end else begin
                        j_d = j_q + 2'd1;
                    end
                end else begin
                    i_d = '0;
                    j_d = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule
